// File: rtl/key_mode_ctrl.sv
// Per-key debouncer with press/release pulses and a per-key toggle flag.
// Define KEY_MODE_LONGPRESS_EN to add long-press detection (toggle then flips on short-press release).
module key_mode_ctrl #(
   parameter int CLK_FREQ       = 27_000_000,
   parameter int KEY_NUM        = 2,
   parameter int DEBOUNCE_MS    = 20,
   parameter int LONG_MS        = 500,
   parameter int KEY_ACTIVE_LOW = 1
) (
   input  logic               I_clk,
   input  logic               I_rst_n,
   input  logic [KEY_NUM-1:0] I_key,
   output logic [KEY_NUM-1:0] O_key_level,
   output logic [KEY_NUM-1:0] O_press_pulse,
   output logic [KEY_NUM-1:0] O_release_pulse,
   output logic [KEY_NUM-1:0] O_toggle,
   output logic [KEY_NUM-1:0] O_long_pulse
);

   localparam int DB_CYC = CLK_FREQ / 1000 * DEBOUNCE_MS;
   localparam int DB_W   = $clog2(DB_CYC) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC);
   localparam logic REL_LVL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

`ifdef KEY_MODE_LONGPRESS_EN
   localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_MS;
   localparam int LONG_W   = $clog2(LONG_CYC) + 1;
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC);
`endif

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

   logic [KEY_NUM-1:0] sync1_q, sync2_q;
   logic [KEY_NUM-1:0] key_n;

   // Synchroniser resets to the released level so a key held through reset is seen as a fresh press.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         sync1_q <= {KEY_NUM{REL_LVL}};
         sync2_q <= {KEY_NUM{REL_LVL}};
      end else begin
         sync1_q <= I_key;
         sync2_q <= sync1_q;
      end
   end

   assign key_n = sync2_q ^ {KEY_NUM{REL_LVL}};

   for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
      state_t          state_q;
      logic [DB_W-1:0] db_cnt_q;
      logic [DB_W-1:0] db_cnt_d;
      logic            db_done;
      logic            press_acc;
      logic            rel_acc;
      logic            toggle_flip;
      logic            level_q, press_q, release_q, toggle_q;

      assign db_cnt_d  = db_cnt_q + 1'b1;
      assign db_done   = (db_cnt_d == DB_LAST);
      // Counter is zero in IDLE/HELD, so a first sample there counts as sample one.
      assign press_acc = key_n[k] && (state_q == IDLE || state_q == PRESS_DB) && db_done;
      assign rel_acc   = !key_n[k] && (state_q == HELD || state_q == RELEASE_DB) && db_done;

`ifdef KEY_MODE_LONGPRESS_EN
      logic [LONG_W-1:0] hold_cnt_q;
      logic [LONG_W-1:0] hold_cnt_d;
      logic              holding;
      logic              long_fire;
      logic              long_q;

      assign holding     = (state_q == HELD) || (state_q == RELEASE_DB);
      assign hold_cnt_d  = hold_cnt_q + 1'b1;
      assign long_fire   = holding && (hold_cnt_d == LONG_LAST);
      assign toggle_flip = rel_acc && !(long_fire || hold_cnt_q == LONG_LAST);

      // Hold counter saturates at LONG_LAST, which also marks that the long pulse was issued.
      always_ff @(posedge I_clk or negedge I_rst_n) begin
         if (!I_rst_n) begin
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
         end else begin
            long_q <= long_fire;
            if (press_acc) begin
               hold_cnt_q <= '0;
            end else if (holding && hold_cnt_q != LONG_LAST) begin
               hold_cnt_q <= hold_cnt_d;
            end
         end
      end

      assign O_long_pulse[k] = long_q;
`else
      assign toggle_flip = press_acc;
`endif

      always_ff @(posedge I_clk or negedge I_rst_n) begin
         if (!I_rst_n) begin
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
         end else begin
            press_q   <= press_acc;
            release_q <= rel_acc;
            toggle_q  <= toggle_q ^ toggle_flip;
            case (state_q)
               IDLE: begin
                  if (press_acc) begin
                     state_q  <= HELD;
                     level_q  <= 1'b1;
                     db_cnt_q <= '0;
                  end else if (key_n[k]) begin
                     state_q  <= PRESS_DB;
                     db_cnt_q <= db_cnt_d;
                  end
               end
               PRESS_DB: begin
                  if (!key_n[k]) begin
                     state_q  <= IDLE;
                     db_cnt_q <= '0;
                  end else if (press_acc) begin
                     state_q  <= HELD;
                     level_q  <= 1'b1;
                     db_cnt_q <= '0;
                  end else begin
                     db_cnt_q <= db_cnt_d;
                  end
               end
               HELD: begin
                  if (rel_acc) begin
                     state_q  <= IDLE;
                     level_q  <= 1'b0;
                     db_cnt_q <= '0;
                  end else if (!key_n[k]) begin
                     state_q  <= RELEASE_DB;
                     db_cnt_q <= db_cnt_d;
                  end
               end
               RELEASE_DB: begin
                  if (key_n[k]) begin
                     state_q  <= HELD;
                     db_cnt_q <= '0;
                  end else if (rel_acc) begin
                     state_q  <= IDLE;
                     level_q  <= 1'b0;
                     db_cnt_q <= '0;
                  end else begin
                     db_cnt_q <= db_cnt_d;
                  end
               end
               default: begin
                  state_q  <= IDLE;
                  db_cnt_q <= '0;
               end
            endcase
         end
      end

      assign O_key_level[k]     = level_q;
      assign O_press_pulse[k]   = press_q;
      assign O_release_pulse[k] = release_q;
      assign O_toggle[k]        = toggle_q;
   end

`ifndef KEY_MODE_LONGPRESS_EN
   assign O_long_pulse = '0;
`endif

endmodule
